// File: rtl/cpu_sram_arb_pkg.sv
// Shared types and constants for the CPU SRAM-like 2:1 arbiter.
// Owner encoding tags each accepted request as inst or data.
// Grant state encodings are used by the lock FSM in the top module.
`ifndef CPU_SRAM_ARB_DEFS
`define CPU_SRAM_ARB_DEFS
`define ARB_OWNER_INST 1'b0
`define ARB_OWNER_DATA 1'b1
`define ARB_ST_IDLE    2'd0
`define ARB_ST_LOCK_I  2'd1
`define ARB_ST_LOCK_D  2'd2
`endif

package cpu_sram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = `ARB_ST_IDLE,
    ST_LOCK_I = `ARB_ST_LOCK_I,
    ST_LOCK_D = `ARB_ST_LOCK_D
  } arb_state_e;

  localparam logic OWNER_INST = `ARB_OWNER_INST;
  localparam logic OWNER_DATA = `ARB_OWNER_DATA;

  // Fixed shape of an instruction fetch on the shared port.
  localparam logic [1:0] INST_SIZE = 2'd2;

endpackage

// File: rtl/cpu_sram_arb_if.sv
// Bundle of the inst-side, data-side and memory-side SRAM-like buses.
// slave: the arbiter's view; master: the environment (CPU core + bridge).
// Pure wiring, no latency; flow control is req/addr_ok and data_ok.
interface cpu_sram_arb_if;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic [31:0] inst_sram_rdata;
  logic        inst_sram_data_ok;

  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic [31:0] data_sram_rdata;
  logic        data_sram_data_ok;

  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic [31:0] mem_rdata;
  logic        mem_data_ok;

  modport slave (
    input  inst_sram_req, inst_sram_addr,
    output inst_sram_addr_ok, inst_sram_rdata, inst_sram_data_ok,
    input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
    input  data_sram_addr, data_sram_wdata,
    output data_sram_addr_ok, data_sram_rdata, data_sram_data_ok,
    output mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
    input  mem_addr_ok, mem_rdata, mem_data_ok
  );

  modport master (
    output inst_sram_req, inst_sram_addr,
    input  inst_sram_addr_ok, inst_sram_rdata, inst_sram_data_ok,
    output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
    output data_sram_addr, data_sram_wdata,
    input  data_sram_addr_ok, data_sram_rdata, data_sram_data_ok,
    input  mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
    output mem_addr_ok, mem_rdata, mem_data_ok
  );
endinterface

// File: rtl/arb_owner_fifo.sv
// 1-bit in-order FIFO recording the owner of each accepted request.
// Ports: push/din write, pop/dout read-ahead, full/empty/count status.
// Latency: dout shows the head combinationally; push when full / pop when empty are ignored.
module arb_owner_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     din,
  output logic                     dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_CNT = DEPTH[PW:0];
  localparam logic [PW:0]   CNT_ONE  = {{PW{1'b0}}, 1'b1};
  localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};

  logic          mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   cnt_q;
  logic          push_en, pop_en;

  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign push_en = push & ~full;
  assign pop_en  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = cnt_q;

  // Storage needs no reset: entries are only read when counted valid.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= din;
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_en)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push_en, pop_en})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/cpu_sram_arb.sv
// 2:1 arbiter (data over inst) onto one SRAM-like port; routes data_ok back by owner.
// Ports: clk/reset, bus (slave modport), spurious_o, state_o, ost_cnt_o (status).
// Latency: zero on request and response paths; grant is held until mem_addr_ok, mem_req drops when owner FIFO full.
module cpu_sram_arb
  import cpu_sram_arb_pkg::*;
#(
  parameter int OST_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  cpu_sram_arb_if.slave              bus,
  output logic                       spurious_o,
  output logic [1:0]                 state_o,
  output logic [$clog2(OST_DEPTH):0] ost_cnt_o
);
  arb_state_e state_q, state_d;
  logic       sel_data;    // 1 = data requester owns the port this cycle
  logic       winner_req;
  logic       accept;
  logic       fifo_full, fifo_empty, fifo_dout;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    sel_data = 1'b0;
    case (state_q)
      ST_IDLE:   sel_data = bus.data_sram_req;
      ST_LOCK_D: sel_data = 1'b1;
      default:   sel_data = 1'b0;
    endcase

    winner_req = sel_data ? bus.data_sram_req : bus.inst_sram_req;
    // A full owner FIFO blocks issue even if it pops this cycle, which
    // keeps the full flag purely registered on the request path.
    bus.mem_req = winner_req & ~fifo_full;
    accept      = bus.mem_req & bus.mem_addr_ok;

    if (sel_data) begin
      bus.mem_wr    = bus.data_sram_wr;
      bus.mem_size  = bus.data_sram_size;
      bus.mem_wstrb = bus.data_sram_wstrb;
      bus.mem_addr  = bus.data_sram_addr;
      bus.mem_wdata = bus.data_sram_wdata;
    end else begin
      bus.mem_wr    = 1'b0;
      bus.mem_size  = INST_SIZE;
      bus.mem_wstrb = 4'h0;
      bus.mem_addr  = bus.inst_sram_addr;
      bus.mem_wdata = 32'h0;
    end

    bus.data_sram_addr_ok = accept & sel_data;
    bus.inst_sram_addr_ok = accept & ~sel_data;

    // Lock on an unaccepted request; while stalled by full, hold state.
    state_d = state_q;
    if (bus.mem_req) begin
      if (bus.mem_addr_ok) state_d = ST_IDLE;
      else                 state_d = sel_data ? ST_LOCK_D : ST_LOCK_I;
    end
  end

  arb_owner_fifo #(
    .DEPTH (OST_DEPTH)
  ) u_owner_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .pop   (bus.mem_data_ok),
    .din   (sel_data ? OWNER_DATA : OWNER_INST),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (ost_cnt_o)
  );

  // Responses are in order, so the FIFO head names the owner.
  assign bus.inst_sram_data_ok = bus.mem_data_ok & ~fifo_empty & (fifo_dout == OWNER_INST);
  assign bus.data_sram_data_ok = bus.mem_data_ok & ~fifo_empty & (fifo_dout == OWNER_DATA);
  assign bus.inst_sram_rdata   = bus.mem_rdata;
  assign bus.data_sram_rdata   = bus.mem_rdata;
  assign spurious_o            = bus.mem_data_ok & fifo_empty;
  assign state_o               = state_q;
endmodule

// File: tb/tb_cpu_sram_arb.sv
module tb_cpu_sram_arb;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOCK_I = 2'd1;

  logic       clk;
  logic       reset;
  logic       spurious;
  logic [1:0] state;
  logic [2:0] ost_cnt;
  int         n_tests;
  int         n_fail;

  cpu_sram_arb_if bus ();

  cpu_sram_arb #(.OST_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .spurious_o (spurious),
    .state_o    (state),
    .ost_cnt_o  (ost_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        i_req;   logic [31:0] i_addr;
    logic        d_req;   logic d_wr; logic [1:0] d_size; logic [3:0] d_wstrb;
    logic [31:0] d_addr;  logic [31:0] d_wdata;
    logic        m_aok;   logic m_dok; logic [31:0] m_rdata;
    logic        e_req;   logic [31:0] e_addr; logic e_wr; logic [1:0] e_size;
    logic [3:0]  e_wstrb; logic [31:0] e_wdata;
    logic        e_iaok;  logic e_daok; logic e_idok; logic e_ddok; logic e_spur;
  } vec_t;

  localparam int NV = 18;
  vec_t vt [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.inst_sram_req   = 1'b0;
    bus.inst_sram_addr  = 32'h0;
    bus.data_sram_req   = 1'b0;
    bus.data_sram_wr    = 1'b0;
    bus.data_sram_size  = 2'd0;
    bus.data_sram_wstrb = 4'h0;
    bus.data_sram_addr  = 32'h0;
    bus.data_sram_wdata = 32'h0;
    bus.mem_addr_ok     = 1'b0;
    bus.mem_data_ok     = 1'b0;
    bus.mem_rdata       = 32'h0;
  endtask

  task automatic apply(input vec_t v);
    bus.inst_sram_req   = v.i_req;
    bus.inst_sram_addr  = v.i_addr;
    bus.data_sram_req   = v.d_req;
    bus.data_sram_wr    = v.d_wr;
    bus.data_sram_size  = v.d_size;
    bus.data_sram_wstrb = v.d_wstrb;
    bus.data_sram_addr  = v.d_addr;
    bus.data_sram_wdata = v.d_wdata;
    bus.mem_addr_ok     = v.m_aok;
    bus.mem_data_ok     = v.m_dok;
    bus.mem_rdata       = v.m_rdata;
  endtask

  task automatic check_vec(input int i, input vec_t v);
    chk($sformatf("v%0d mem_req", i),   {31'b0, bus.mem_req},   {31'b0, v.e_req});
    chk($sformatf("v%0d mem_addr", i),  bus.mem_addr,           v.e_addr);
    chk($sformatf("v%0d mem_wr", i),    {31'b0, bus.mem_wr},    {31'b0, v.e_wr});
    chk($sformatf("v%0d mem_size", i),  {30'b0, bus.mem_size},  {30'b0, v.e_size});
    chk($sformatf("v%0d mem_wstrb", i), {28'b0, bus.mem_wstrb}, {28'b0, v.e_wstrb});
    chk($sformatf("v%0d mem_wdata", i), bus.mem_wdata,          v.e_wdata);
    chk($sformatf("v%0d inst_aok", i),  {31'b0, bus.inst_sram_addr_ok}, {31'b0, v.e_iaok});
    chk($sformatf("v%0d data_aok", i),  {31'b0, bus.data_sram_addr_ok}, {31'b0, v.e_daok});
    chk($sformatf("v%0d inst_dok", i),  {31'b0, bus.inst_sram_data_ok}, {31'b0, v.e_idok});
    chk($sformatf("v%0d data_dok", i),  {31'b0, bus.data_sram_data_ok}, {31'b0, v.e_ddok});
    chk($sformatf("v%0d spurious", i),  {31'b0, spurious},      {31'b0, v.e_spur});
    chk($sformatf("v%0d inst_rdata", i), bus.inst_sram_rdata,   v.m_rdata);
    chk($sformatf("v%0d data_rdata", i), bus.data_sram_rdata,   v.m_rdata);
  endtask

  initial begin
    logic [9:0] own;
    n_tests = 0;
    n_fail  = 0;

    // Fields: i_req,i_addr, d_req,d_wr,d_size,d_wstrb,d_addr,d_wdata, m_aok,m_dok,m_rdata,
    //         e_req,e_addr,e_wr,e_size,e_wstrb,e_wdata, e_iaok,e_daok,e_idok,e_ddok,e_spur
    // Priority: data wins first, inst next cycle; FIFO = D,I.
    vt[0]  = '{1,32'hbfc00000, 1,1,2'd2,4'hf,32'h80000010,32'h12345678, 1,0,32'h0,
               1,32'h80000010,1,2'd2,4'hf,32'h12345678, 0,1,0,0,0};
    vt[1]  = '{1,32'hbfc00000, 0,0,2'd0,4'h0,32'h0,32'h0, 1,0,32'h0,
               1,32'hbfc00000,0,2'd2,4'h0,32'h0, 1,0,0,0,0};
    vt[2]  = '{0,32'h0, 0,0,2'd0,4'h0,32'h0,32'h0, 0,1,32'h11,
               0,32'h0,0,2'd2,4'h0,32'h0, 0,0,0,1,0};
    vt[3]  = '{0,32'h0, 0,0,2'd0,4'h0,32'h0,32'h0, 0,1,32'h22,
               0,32'h0,0,2'd2,4'h0,32'h0, 0,0,1,0,0};
    // Lock hold: inst locked for 3 stalled cycles, data arrives in cycle 1.
    vt[4]  = '{1,32'hbfc00004, 0,0,2'd0,4'h0,32'h0,32'h0, 0,0,32'h0,
               1,32'hbfc00004,0,2'd2,4'h0,32'h0, 0,0,0,0,0};
    vt[5]  = '{1,32'hbfc00004, 1,1,2'd1,4'h3,32'h80000020,32'hdeadbeef, 0,0,32'h0,
               1,32'hbfc00004,0,2'd2,4'h0,32'h0, 0,0,0,0,0};
    vt[6]  = vt[5];
    vt[7]  = '{1,32'hbfc00004, 1,1,2'd1,4'h3,32'h80000020,32'hdeadbeef, 1,0,32'h0,
               1,32'hbfc00004,0,2'd2,4'h0,32'h0, 1,0,0,0,0};
    vt[8]  = '{1,32'hbfc00008, 1,1,2'd1,4'h3,32'h80000020,32'hdeadbeef, 1,0,32'h0,
               1,32'h80000020,1,2'd1,4'h3,32'hdeadbeef, 0,1,0,0,0};
    vt[9]  = '{0,32'h0, 0,0,2'd0,4'h0,32'h0,32'h0, 0,1,32'h33,
               0,32'h0,0,2'd2,4'h0,32'h0, 0,0,1,0,0};
    vt[10] = '{0,32'h0, 0,0,2'd0,4'h0,32'h0,32'h0, 0,1,32'h44,
               0,32'h0,0,2'd2,4'h0,32'h0, 0,0,0,1,0};
    // In-order routing: accept I, D, I then three responses.
    vt[11] = '{1,32'hbfc00008, 0,0,2'd0,4'h0,32'h0,32'h0, 1,0,32'h0,
               1,32'hbfc00008,0,2'd2,4'h0,32'h0, 1,0,0,0,0};
    vt[12] = '{0,32'h0, 1,0,2'd0,4'h0,32'h80000031,32'h0, 1,0,32'h0,
               1,32'h80000031,0,2'd0,4'h0,32'h0, 0,1,0,0,0};
    vt[13] = '{1,32'hbfc0000c, 0,0,2'd0,4'h0,32'h0,32'h0, 1,0,32'h0,
               1,32'hbfc0000c,0,2'd2,4'h0,32'h0, 1,0,0,0,0};
    vt[14] = '{0,32'h0, 0,0,2'd0,4'h0,32'h0,32'h0, 0,1,32'hA,
               0,32'h0,0,2'd2,4'h0,32'h0, 0,0,1,0,0};
    vt[15] = '{0,32'h0, 0,0,2'd0,4'h0,32'h0,32'h0, 0,1,32'hB,
               0,32'h0,0,2'd2,4'h0,32'h0, 0,0,0,1,0};
    vt[16] = '{0,32'h0, 0,0,2'd0,4'h0,32'h0,32'h0, 0,1,32'hC,
               0,32'h0,0,2'd2,4'h0,32'h0, 0,0,1,0,0};
    // Spurious response with empty FIFO.
    vt[17] = '{0,32'h0, 0,0,2'd0,4'h0,32'h0,32'h0, 0,1,32'h5,
               0,32'h0,0,2'd2,4'h0,32'h0, 0,0,0,0,1};

    // Reset state.
    clr();
    reset = 1'b1;
    tick();
    tick();
    chk("reset state", {30'b0, state}, {30'b0, S_IDLE});
    chk("reset count", {29'b0, ost_cnt}, 32'd0);
    chk("reset mem_req", {31'b0, bus.mem_req}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      apply(vt[i]);
      #2;
      check_vec(i, vt[i]);
      tick();
      if (i == 1)  chk("fifo D,I count", {29'b0, ost_cnt}, 32'd2);
      if (i == 6)  chk("lock_i held", {30'b0, state}, {30'b0, S_LOCK_I});
    end
    chk("spurious count", {29'b0, ost_cnt}, 32'd0);

    // Full stall: four inst acceptances, then stall even with a same-cycle pop.
    clr();
    for (int k = 0; k < 4; k++) begin
      bus.inst_sram_req  = 1'b1;
      bus.inst_sram_addr = 32'hbfc00100 + 32'(k * 4);
      bus.mem_addr_ok    = 1'b1;
      #2;
      chk($sformatf("fill%0d inst_aok", k), {31'b0, bus.inst_sram_addr_ok}, 32'd1);
      tick();
    end
    #2;
    chk("full mem_req", {31'b0, bus.mem_req}, 32'd0);
    chk("full inst_aok", {31'b0, bus.inst_sram_addr_ok}, 32'd0);
    chk("full count", {29'b0, ost_cnt}, 32'd4);
    tick();
    chk("full state", {30'b0, state}, {30'b0, S_IDLE});
    bus.mem_data_ok = 1'b1;
    bus.mem_rdata   = 32'h55;
    #2;
    chk("full+pop mem_req", {31'b0, bus.mem_req}, 32'd0);
    chk("full+pop inst_dok", {31'b0, bus.inst_sram_data_ok}, 32'd1);
    tick();
    bus.mem_data_ok = 1'b0;
    #2;
    chk("after pop count", {29'b0, ost_cnt}, 32'd3);
    chk("after pop mem_req", {31'b0, bus.mem_req}, 32'd1);
    chk("after pop inst_aok", {31'b0, bus.inst_sram_addr_ok}, 32'd1);
    tick();
    chk("refill count", {29'b0, ost_cnt}, 32'd4);
    clr();
    for (int k = 0; k < 4; k++) begin
      bus.mem_data_ok = 1'b1;
      #2;
      chk($sformatf("drain%0d inst_dok", k), {31'b0, bus.inst_sram_data_ok}, 32'd1);
      chk($sformatf("drain%0d data_dok", k), {31'b0, bus.data_sram_data_ok}, 32'd0);
      tick();
    end
    clr();
    chk("drained count", {29'b0, ost_cnt}, 32'd0);

    // Reset mid-operation with two outstanding and a held lock.
    bus.inst_sram_req = 1'b1;
    bus.mem_addr_ok   = 1'b1;
    tick();
    bus.inst_sram_req = 1'b0;
    bus.data_sram_req = 1'b1;
    tick();
    bus.data_sram_req = 1'b0;
    bus.inst_sram_req = 1'b1;
    bus.mem_addr_ok   = 1'b0;
    tick();
    chk("pre-reset count", {29'b0, ost_cnt}, 32'd2);
    chk("pre-reset state", {30'b0, state}, {30'b0, S_LOCK_I});
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clr();
    chk("post-reset count", {29'b0, ost_cnt}, 32'd0);
    chk("post-reset state", {30'b0, state}, {30'b0, S_IDLE});
    bus.mem_data_ok = 1'b1;
    #2;
    chk("late dok spurious", {31'b0, spurious}, 32'd1);
    chk("late dok inst", {31'b0, bus.inst_sram_data_ok}, 32'd0);
    chk("late dok data", {31'b0, bus.data_sram_data_ok}, 32'd0);
    tick();
    clr();
    chk("late dok count", {29'b0, ost_cnt}, 32'd0);

    // Wrap-around: each cycle pushes one owner and pops the previous one.
    own = 10'b1011001101;
    for (int i = 0; i <= 10; i++) begin
      clr();
      if (i < 10) begin
        if (own[i]) begin
          bus.data_sram_req  = 1'b1;
          bus.data_sram_addr = 32'h80000100 + 32'(i);
        end else begin
          bus.inst_sram_req  = 1'b1;
          bus.inst_sram_addr = 32'hbfc00200 + 32'(i * 4);
        end
        bus.mem_addr_ok = 1'b1;
      end
      if (i > 0) begin
        bus.mem_data_ok = 1'b1;
        bus.mem_rdata   = 32'h100 + 32'(i - 1);
      end
      #2;
      if (i < 10)
        chk($sformatf("wrap%0d aok", i),
            {31'b0, (own[i] ? bus.data_sram_addr_ok : bus.inst_sram_addr_ok)}, 32'd1);
      if (i > 0) begin
        chk($sformatf("wrap%0d inst_dok", i), {31'b0, bus.inst_sram_data_ok}, {31'b0, ~own[i-1]});
        chk($sformatf("wrap%0d data_dok", i), {31'b0, bus.data_sram_data_ok}, {31'b0, own[i-1]});
        chk($sformatf("wrap%0d rdata", i), bus.inst_sram_rdata, 32'h100 + 32'(i - 1));
      end
      tick();
      chk($sformatf("wrap%0d count", i), {29'b0, ost_cnt}, (i < 10) ? 32'd1 : 32'd0);
    end
    clr();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
